i2s_rx: RTL
===========

// Module: i2s_rx
// PURPOSE
//  I2S receiver (ADC direction) for the audio codec Pmod: counterpart to the serial DAC transmit path.
//  Generates mclk/lrck/sck from the system clock, deserialises audio_sdin into 24-bit left/right words
//  and presents each stereo pair with a valid/ready handshake. Fully synchronous to clk, clocks as enables.
// PARAMETERS
//  DATA_W      24  sample width per channel (1..BITS_PER_CH-1)
//  BITS_PER_CH 32  sck periods per lrck half-frame
//  SCK_HALF    8   clk cycles per sck half-period (power of 2, >=4)
//  MCLK_HALF   2   clk cycles per mclk half-period (power of 2, <=SCK_HALF)
// PORTS
//  clk           in   1       system clock (100 MHz)
//  rst           in   1       synchronous reset, active low
//  audio_sdin    in   1       serial data from ADC, changes on falling audio_sck
//  audio_mclk    out  1       master clock, clk/(2*MCLK_HALF)
//  audio_lrck    out  1       word select: 0 = left, 1 = right
//  audio_sck     out  1       serial bit clock, clk/(2*SCK_HALF)
//  left_data     out  DATA_W  last completed left sample, MSB first on wire
//  right_data    out  DATA_W  last completed right sample
//  sample_valid  out  1       stereo pair available
//  sample_ready  in   1       consumer accepts pair when high with sample_valid
//  overrun       out  1       sticky: a pair was overwritten before acceptance
//  clear_overrun in   1       clears overrun (one clk pulse)
// BEHAVIOUR
//  - Reset (rst==0 at posedge clk): frame counter, shift regs, sync flops, all outputs -> 0. Mid-frame reset
//    discards partial capture; lrck restarts low; first valid only after a complete new frame.
//  - frame_cnt: 0..FRAME-1, FRAME = 2*BITS_PER_CH*2*SCK_HALF (1024 default), wraps to 0.
//  - Registered clocks from frame_cnt: mclk = frame_cnt[log2(MCLK_HALF)], sck high when
//    frame_cnt mod 2*SCK_HALF >= SCK_HALF, lrck = (frame_cnt >= FRAME/2). All glitch-free flops.
//  - slot = (frame_cnt / 2*SCK_HALF) mod BITS_PER_CH. I2S 1-bit delay: MSB in slot 1, LSB in slot DATA_W;
//    slot 0 and slots > DATA_W ignored (padding).
//  - audio_sdin passes a 2-flop synchroniser; sampled when frame_cnt mod 2*SCK_HALF == SCK_HALF+SCK_HALF/2
//    (mid sck-high) and slot in 1..DATA_W; shifted MSB-first into left_sr (lrck=0) or right_sr (lrck=1).
//  - Pair complete at the right-channel LSB sample tick; next clk: left_data<=left_sr, right_data<=right_sr,
//    sample_valid<=1. Latency: 1 clk after final sample tick.
//  - Handshake: sample_valid && sample_ready -> valid clears next clk unless a new pair completes same cycle
//    (then new data loads, valid stays 1, no overrun). valid held, data stable, until accepted.
//  - Completion while valid && !ready: data overwritten with new pair, valid stays 1, overrun<=1.
//  - overrun clears only on reset or clear_overrun; clear_overrun and set same cycle -> set wins.
//  - sample_ready without valid: no effect.
// STRUCTURE
//  - Package audio_i2s_pkg: DATA_W, BITS_PER_CH, SCK_HALF, MCLK_HALF defaults, FRAME, sample-tick offset
//    constant; shared with the DAC transmit path.
//  - Sub-module i2s_clk_gen: frame counter + registered mclk/sck/lrck, exports slot, lrck and
//    sample_tick strobes. i2s_rx holds synchroniser, shift regs, output regs, handshake/overrun logic.
// TESTING (bench ADC model drives audio_sdin on falling DUT audio_sck, standard I2S)
//  1. rst=0 for 5 clk mid-operation -> all outputs 0 from next clk; lrck low for first 512 clk after release.
//  2. Free run -> mclk period 4 clk, sck period 16 clk, lrck period 1024 clk with 50% duty.
//  3. L=24'hA5A5A5, R=24'h5A5A5A, ready=1 -> left_data/right_data match, valid 1-clk pulse once per frame.
//  4. ready=0 for 2 frames (L=1,2) -> valid held, data = frame 2, overrun=1; ready pulse -> valid 0,
//     overrun stays 1 until clear_overrun pulse.
//  5. rst low at frame_cnt=300 -> partial pair dropped; next valid exactly 1 full frame (+latency) later.
//  6. L=24'h800000, R=24'h000001, padding/slot0 bits driven 1 -> outputs exactly 24'h800000 / 24'h000001.

Source files
------------

// File: rtl/audio_i2s_pkg.sv
// Shared constants for the codec I2S link (ADC receive and DAC transmit paths).
// Default sizes, frame length and the mid-sck-high capture offset.
package audio_i2s_pkg;

  localparam int I2S_DATA_W      = 24;
  localparam int I2S_BITS_PER_CH = 32;
  localparam int I2S_SCK_HALF    = 8;
  localparam int I2S_MCLK_HALF   = 2;

  function automatic int frame_len(input int bits_per_ch, input int sck_half);
    return 2 * bits_per_ch * 2 * sck_half;
  endfunction

  // Capture point sits in the middle of the sck-high half of each bit slot.
  function automatic int sample_ofs(input int sck_half);
    return sck_half + sck_half / 2;
  endfunction

  localparam int I2S_FRAME      = frame_len(I2S_BITS_PER_CH, I2S_SCK_HALF);
  localparam int I2S_SAMPLE_OFS = sample_ofs(I2S_SCK_HALF);

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S frame timing: one frame counter held as {chan, slot, phase} fields, registered
// mclk/sck/lrck derived from it, and the per-bit capture strobe for data slots.
module i2s_clk_gen import audio_i2s_pkg::*; #(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int BITS_PER_CH = I2S_BITS_PER_CH,
  parameter int SCK_HALF    = I2S_SCK_HALF,
  parameter int MCLK_HALF   = I2S_MCLK_HALF,
  parameter int SLOT_W      = $clog2(BITS_PER_CH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              audio_mclk,
  output logic              audio_sck,
  output logic              audio_lrck,
  output logic [SLOT_W-1:0] slot,
  output logic              chan,
  output logic              sample_tick
);

  localparam int PHASE_W  = $clog2(2 * SCK_HALF);
  localparam int MCLK_BIT = $clog2(MCLK_HALF);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * SCK_HALF - 1);
  localparam logic [PHASE_W-1:0] PHASE_TICK = PHASE_W'(sample_ofs(SCK_HALF));
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(BITS_PER_CH - 1);
  localparam logic [SLOT_W-1:0]  SLOT_MSB   = SLOT_W'(1);
  localparam logic [SLOT_W-1:0]  SLOT_LSB   = SLOT_W'(DATA_W);

  logic [PHASE_W-1:0] phase;

  // Phase wraps on its own since 2*SCK_HALF is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase <= '0;
      slot  <= '0;
      chan  <= 1'b0;
    end else begin
      phase <= phase + PHASE_W'(1);
      if (phase == PHASE_LAST) begin
        if (slot == SLOT_LAST) begin
          slot <= '0;
          chan <= ~chan;
        end else begin
          slot <= slot + SLOT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      audio_mclk <= 1'b0;
      audio_sck  <= 1'b0;
      audio_lrck <= 1'b0;
    end else begin
      audio_mclk <= phase[MCLK_BIT];
      audio_sck  <= phase[PHASE_W-1];
      audio_lrck <= chan;
    end
  end

  // Slot 0 is the I2S one-bit delay; slots past the LSB are padding.
  assign sample_tick = (phase == PHASE_TICK) && (slot >= SLOT_MSB) && (slot <= SLOT_LSB);

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver for the codec ADC: synchronises audio_sdin, deserialises left/right
// words MSB first, and offers each stereo pair on a valid/ready port with sticky overrun.
module i2s_rx import audio_i2s_pkg::*; #(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int BITS_PER_CH = I2S_BITS_PER_CH,
  parameter int SCK_HALF    = I2S_SCK_HALF,
  parameter int MCLK_HALF   = I2S_MCLK_HALF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              audio_sdin,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              clear_overrun
);

  localparam int SLOT_W = $clog2(BITS_PER_CH);
  localparam logic [SLOT_W-1:0] SLOT_LSB = SLOT_W'(DATA_W);

  logic [SLOT_W-1:0] slot;
  logic              chan;
  logic              sample_tick;
  logic              pair_done;
  logic              sdin_p0, sdin_p1;
  logic [DATA_W-1:0] left_sr, right_sr;
  logic              done_p1;

  i2s_clk_gen #(
    .DATA_W      (DATA_W),
    .BITS_PER_CH (BITS_PER_CH),
    .SCK_HALF    (SCK_HALF),
    .MCLK_HALF   (MCLK_HALF),
    .SLOT_W      (SLOT_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .audio_mclk  (audio_mclk),
    .audio_sck   (audio_sck),
    .audio_lrck  (audio_lrck),
    .slot        (slot),
    .chan        (chan),
    .sample_tick (sample_tick)
  );

  assign pair_done = sample_tick && chan && (slot == SLOT_LSB);

  // Stage p0/p1: two-flop synchroniser on the ADC data line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sdin_p0 <= 1'b0;
      sdin_p1 <= 1'b0;
    end else begin
      sdin_p0 <= audio_sdin;
      sdin_p1 <= sdin_p0;
    end
  end

  // Stage p1 -> shift: capture one bit per data slot; the right LSB ends the pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      left_sr  <= '0;
      right_sr <= '0;
      done_p1  <= 1'b0;
    end else begin
      done_p1 <= pair_done;
      if (sample_tick) begin
        if (chan) right_sr <= DATA_W'({right_sr, sdin_p1});
        else      left_sr  <= DATA_W'({left_sr, sdin_p1});
      end
    end
  end

  // Output stage: a completing pair always loads; overwriting an unaccepted pair flags overrun.
  always_ff @(posedge clk) begin
    if (!rst) begin
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (done_p1) begin
        left_data    <= left_sr;
        right_data   <= right_sr;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (done_p1 && sample_valid && !sample_ready) overrun <= 1'b1;
      else if (clear_overrun)                       overrun <= 1'b0;
    end
  end

endmodule
